// File: rtl/lookup_map_interp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lookup_map_interp_pkg : stream constants and mode/op encodings        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package lookup_map_interp_pkg;

    localparam int DTYPE_WIDTH = 4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;

    localparam logic [1:0] LMI_MODE_BYPASS  = 2'd0;
    localparam logic [1:0] LMI_MODE_NEAREST = 2'd1;
    localparam logic [1:0] LMI_MODE_INTERP  = 2'd2;

    typedef enum logic [1:0] {
        OP_BYPASS  = 2'd0,
        OP_NEAREST = 2'd1,
        OP_INTERP  = 2'd2
    } lmi_op_e;

    // Mode 3 and a deasserted enable both collapse to a straight pass-through.
    function automatic lmi_op_e lmi_op(input logic enable, input logic [1:0] mode);
        lmi_op_e op;
        op = OP_BYPASS;
        if (enable) begin
            case (mode)
                LMI_MODE_NEAREST: op = OP_NEAREST;
                LMI_MODE_INTERP:  op = OP_INTERP;
                default:          op = OP_BYPASS;
            endcase
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lookup_map_interp_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lookup_map_interp_chan : one channel, two knot banks, 3-stage mapper  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module lookup_map_interp_chan
    import lookup_map_interp_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int KNOT_BITS   = 5
) (
    input  logic                   pixclk,
    input  logic                   reset,
    input  logic [PIXEL_WIDTH-1:0] x_i,
    input  lmi_op_e                op_i,
    input  logic                   bank_i,
    input  logic                   we_i,
    input  logic                   wbank_i,
    input  logic [KNOT_BITS:0]     waddr_i,
    input  logic [PIXEL_WIDTH:0]   wdata_i,
    output logic [PIXEL_WIDTH-1:0] y_o
);

    localparam int F  = PIXEL_WIDTH - KNOT_BITS;
    localparam int NK = (1 << KNOT_BITS) + 1;
    localparam int DW = PIXEL_WIDTH + 2;
    localparam int PW = DW + F;
    localparam logic signed [PW-1:0] C_HALF = PW'(1 << (F - 1));
    localparam logic signed [PW-1:0] C_MAX  = PW'((1 << PIXEL_WIDTH) - 1);

    logic [PIXEL_WIDTH:0] bank0_q [NK];
    logic [PIXEL_WIDTH:0] bank1_q [NK];

    logic [KNOT_BITS:0]      w_idx0, w_idx1;
    logic [PIXEL_WIDTH:0]    w_k0, w_k1;
    logic [PIXEL_WIDTH-1:0]  x1_q, x2_q, y_q, y_d;
    logic [PIXEL_WIDTH:0]    k0_1_q, k1_1_q, k0_2_q;
    lmi_op_e                 op1_q, op2_q;
    logic signed [DW-1:0]    w_diff;
    logic signed [PW-1:0]    w_diff_x, w_frac_x, w_prod, prod2_q;
    logic signed [PW-1:0]    w_step, w_k0_x, w_sum, w_pre;
    logic [PIXEL_WIDTH-1:0]  w_y;

    // Knot storage is deliberately left without reset.
    always_ff @(posedge pixclk) begin
        if (we_i && !wbank_i) bank0_q[waddr_i] <= wdata_i;
        if (we_i &&  wbank_i) bank1_q[waddr_i] <= wdata_i;
    end

    always_comb begin
        w_idx0 = {1'b0, x_i[PIXEL_WIDTH-1 -: KNOT_BITS]};
        w_idx1 = w_idx0 + (KNOT_BITS+1)'(1);
        w_k0   = bank_i ? bank1_q[w_idx0] : bank0_q[w_idx0];
        w_k1   = bank_i ? bank1_q[w_idx1] : bank0_q[w_idx1];

        w_diff   = signed'({1'b0, k1_1_q}) - signed'({1'b0, k0_1_q});
        w_diff_x = {{F{w_diff[DW-1]}}, w_diff};
        w_frac_x = {{(PW-F){1'b0}}, x1_q[F-1:0]};
        w_prod   = w_diff_x * w_frac_x;

        w_step = (prod2_q + C_HALF) >>> F;
        w_k0_x = {{(PW-PIXEL_WIDTH-1){1'b0}}, k0_2_q};
        w_sum  = w_k0_x + w_step;
        w_pre  = (op2_q == OP_INTERP) ? w_sum : w_k0_x;

        if (w_pre[PW-1])       w_y = '0;
        else if (w_pre > C_MAX) w_y = '1;
        else                    w_y = w_pre[PIXEL_WIDTH-1:0];

        y_d = (op2_q == OP_BYPASS) ? x2_q : w_y;
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            x1_q    <= '0;
            k0_1_q  <= '0;
            k1_1_q  <= '0;
            op1_q   <= OP_BYPASS;
            x2_q    <= '0;
            k0_2_q  <= '0;
            prod2_q <= '0;
            op2_q   <= OP_BYPASS;
            y_q     <= '0;
        end else begin
            x1_q    <= x_i;
            k0_1_q  <= w_k0;
            k1_1_q  <= w_k1;
            op1_q   <= op_i;
            x2_q    <= x1_q;
            k0_2_q  <= k0_1_q;
            prod2_q <= w_prod;
            op2_q   <= op1_q;
            y_q     <= y_d;
        end
    end

    assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/lookup_map_interp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lookup_map_interp : per-channel piecewise-linear tone map, frame-     |
// | synchronous double-buffered knot tables. Rev 1.0                      |
// +----------------------------------------------------------------------+
module lookup_map_interp
    import lookup_map_interp_pkg::*;
#(
    parameter int  PIXEL_WIDTH  = 10,
    parameter int  NUM_CHANNELS = 3,
    parameter int  KNOT_BITS    = 5,
    localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                pixclk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [1:0]                          mode,
    input  logic                                lut_we,
    input  logic [CHAN_W-1:0]                   lut_chan,
    input  logic [KNOT_BITS:0]                  lut_addr,
    input  logic [PIXEL_WIDTH:0]                lut_data,
    input  logic                                swap_req,
    output logic                                swap_pending,
    input  logic                                dvi,
    input  logic [DTYPE_WIDTH-1:0]              dtypei,
    input  logic [15:0]                         meta_datai,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] pixi,
    output logic                                dvo,
    output logic [DTYPE_WIDTH-1:0]              dtypeo,
    output logic [15:0]                         meta_datao,
    output logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] pixo
);

    logic                    w_frame_start, w_swap, w_wr_ok;
    logic                    active_bank_q, active_bank_d;
    logic                    swap_pending_q, swap_pending_d;
    logic [1:0]              mode_q, mode_d;
    lmi_op_e                 w_op;
    logic [NUM_CHANNELS-1:0] w_we;
    logic [2:0]              dv_q;
    logic [DTYPE_WIDTH-1:0]  dtype_q [3];
    logic [15:0]             meta_q [3];

    // Bank and mode take effect combinationally so the frame-start pixel already uses them.
    always_comb begin
        w_frame_start  = dvi && (dtypei == DTYPE_FRAME_START);
        w_swap         = w_frame_start && swap_pending_q;
        active_bank_d  = active_bank_q ^ w_swap;
        mode_d         = w_frame_start ? mode : mode_q;
        swap_pending_d = w_swap ? 1'b0 : (swap_pending_q | swap_req);
        w_op           = lmi_op(enable, mode_d);
        w_wr_ok        = lut_we && !swap_pending_q
                         && (int'(lut_chan) < NUM_CHANNELS)
                         && (int'(lut_addr) <= (1 << KNOT_BITS));
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            mode_q         <= LMI_MODE_BYPASS;
        end else begin
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            mode_q         <= mode_d;
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            dv_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dtype_q[i] <= '0;
                meta_q[i]  <= '0;
            end
        end else begin
            dv_q       <= {dv_q[1:0], dvi};
            dtype_q[0] <= dtypei;
            meta_q[0]  <= meta_datai;
            for (int i = 1; i < 3; i++) begin
                dtype_q[i] <= dtype_q[i-1];
                meta_q[i]  <= meta_q[i-1];
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        assign w_we[g] = w_wr_ok && (int'(lut_chan) == g);

        lookup_map_interp_chan #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .KNOT_BITS   (KNOT_BITS)
        ) u_chan (
            .pixclk  (pixclk),
            .reset   (reset),
            .x_i     (pixi[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .op_i    (w_op),
            .bank_i  (active_bank_d),
            .we_i    (w_we[g]),
            .wbank_i (~active_bank_q),
            .waddr_i (lut_addr),
            .wdata_i (lut_data),
            .y_o     (pixo[g*PIXEL_WIDTH +: PIXEL_WIDTH])
        );
    end

    assign swap_pending = swap_pending_q;
    assign dvo          = dv_q[2];
    assign dtypeo       = dtype_q[2];
    assign meta_datao   = meta_q[2];

endmodule
`default_nettype wire
